// File: rtl/rv_core_pkg.sv
// Core-wide widths and RISC-V load funct3 encodings shared by the integer pipeline.
package rv_core_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for buffered load returns; read data is the head, valid while !empty_o.
// One cycle from push to visibility at the head; push ignored when full, pop ignored when empty.
module wb_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: ALU results direct, load returns buffered and extended.
// ALU result written 1 cycle after accept, loads 2 cycles after enqueue; both stall while the load buffer is full.
module regfile_writeback #(
    parameter int DATA_W     = rv_core_pkg::DATA_W,
    parameter int ADDR_W     = rv_core_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic [2:0]        lsu_funct3,
    input  logic [1:0]        lsu_addr_lo,
    output logic              lsu_ready,
    output logic              regwrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic [CNT_W-1:0]  fifo_count
);
    import rv_core_pkg::*;

    localparam int ENT_W = ADDR_W + 3 + 2 + DATA_W;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] w,
                                                      input logic [2:0]        f3,
                                                      input logic [1:0]        lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (f3)
            F3_LB:   load_extend = {{(DATA_W-8){b[7]}}, b};
            F3_LH:   load_extend = {{(DATA_W-16){h[15]}}, h};
            F3_LBU:  load_extend = {{(DATA_W-8){1'b0}}, b};
            F3_LHU:  load_extend = {{(DATA_W-16){1'b0}}, h};
            default: load_extend = w;
        endcase
    endfunction

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, issue_alu;
    logic [ENT_W-1:0]  head;
    logic [ADDR_W-1:0] head_rd;
    logic [2:0]        head_f3;
    logic [1:0]        head_lo;
    logic [DATA_W-1:0] head_dat;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_dat;

    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (fifo_push),
        .push_dat_i ({lsu_rd, lsu_funct3, lsu_addr_lo, lsu_data}),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign {head_rd, head_f3, head_lo, head_dat} = head;

    // A full buffer always wins the port so the ALU cannot starve loads forever.
    assign lsu_ready = !fifo_full;
    assign alu_ready = !fifo_full;
    assign fifo_push = lsu_valid && !fifo_full;
    assign issue_alu = alu_valid && !fifo_full;
    assign fifo_pop  = fifo_full || (!alu_valid && !fifo_empty);

    always_comb begin
        sel_rd  = alu_rd;
        sel_dat = alu_data;
        if (!issue_alu) begin
            sel_rd  = head_rd;
            sel_dat = load_extend(head_dat, head_f3, head_lo);
        end
        regwrite_d   = (issue_alu || fifo_pop) && (sel_rd != '0);
        write_reg_d  = regwrite_d ? sel_rd  : write_reg_q;
        write_data_d = regwrite_d ? sel_dat : write_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign regwrite   = regwrite_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
endmodule
